markov_step_engine: RTL and testbench

MARKOV_STEP_ENGINE -- requirements
Module: markov_step_engine

---
 rtl/markov_pkg.sv | 16 +
 rtl/markov_flow_mac.sv | 34 +++
 rtl/markov_step_engine.sv | 231 +++++++++++++++++++++++
 tb/tb_markov_step_engine.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/markov_pkg.sv
// Shared definitions for the Markov population step engine.
package markov_pkg;

    localparam int unsigned N_STATES_DEF = 4;
    localparam int unsigned X_W_DEF      = 32;
    localparam int unsigned COEF_W_DEF   = 5;
    localparam int unsigned ITER_W_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLOW   = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/markov_flow_mac.sv
// Registered multiply-shift: f = floor(x * e / 2^COEF_W), one cycle of latency.
module markov_flow_mac #(
    parameter int unsigned X_W    = 32,
    parameter int unsigned COEF_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [X_W-1:0]    x,
    input  logic [COEF_W-1:0] e,
    output logic [X_W-1:0]    f
);

    logic [X_W+COEF_W-1:0] prod;
    logic [X_W-1:0]        f_d;
    logic [X_W-1:0]        f_q;

    // Full-width product, then drop the fractional COEF_W bits.
    always_comb begin
        prod = {{COEF_W{1'b0}}, x} * {{X_W{1'b0}}, e};
        f_d  = prod[X_W+COEF_W-1:COEF_W];
    end

    // Output register for the flow amount.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_q <= '0;
        end else begin
            f_q <= f_d;
        end
    end

    assign f = f_q;

endmodule

// File: rtl/markov_step_engine.sv
// Iterates a population state vector through K Markov flow steps.
module markov_step_engine
    import markov_pkg::*;
#(
    parameter int unsigned N_STATES = N_STATES_DEF,
    parameter int unsigned X_W      = X_W_DEF,
    parameter int unsigned COEF_W   = COEF_W_DEF,
    parameter int unsigned ITER_W   = ITER_W_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             set,
    input  logic [N_STATES*N_STATES*COEF_W-1:0] coef_in,
    input  logic                             start,
    input  logic [N_STATES*X_W-1:0]          x_in,
    input  logic [ITER_W-1:0]                iter_in,
    output logic                             busy,
    output logic                             done,
    output logic [N_STATES*X_W-1:0]          x_out,
    output logic [ITER_W-1:0]                step_cnt,
    output logic                             coef_err,
    output logic                             ovf
);

    localparam int unsigned IDX_W  = $clog2(N_STATES);
    localparam int unsigned CI_W   = $clog2(N_STATES*N_STATES);
    localparam int unsigned ACC_W  = X_W + COEF_W + $clog2(N_STATES);
    localparam int unsigned SUM_W  = COEF_W + $clog2(N_STATES) + 1;
    localparam logic [SUM_W-1:0] ROW_LIMIT = SUM_W'(1) << COEF_W;
    localparam logic [ACC_W:0]   X_MAX     = {{(ACC_W+1-X_W){1'b0}}, {X_W{1'b1}}};

    state_t             state_q, state_d;
    logic [COEF_W-1:0]  coef_q [N_STATES*N_STATES];
    logic [COEF_W-1:0]  coef_d [N_STATES*N_STATES];
    logic [X_W-1:0]     x_q    [N_STATES];
    logic [X_W-1:0]     x_d    [N_STATES];
    logic [ACC_W-1:0]   out_acc_q [N_STATES];
    logic [ACC_W-1:0]   out_acc_d [N_STATES];
    logic [ACC_W-1:0]   in_acc_q  [N_STATES];
    logic [ACC_W-1:0]   in_acc_d  [N_STATES];
    logic [ITER_W-1:0]  k_q, k_d;
    logic [ITER_W-1:0]  step_q, step_d;
    logic               ovf_q, ovf_d;
    logic [IDX_W-1:0]   src_q, src_d;
    logic [IDX_W-1:0]   dst_q, dst_d;
    logic               pend_vld_q, pend_vld_d;
    logic [IDX_W-1:0]   pend_src_q, pend_src_d;
    logic [IDX_W-1:0]   pend_dst_q, pend_dst_d;

    logic [X_W-1:0]     mac_x;
    logic [COEF_W-1:0]  mac_e;
    logic [X_W-1:0]     mac_f;
    logic [CI_W-1:0]    mac_ci;
    logic [SUM_W-1:0]   row_sum;
    logic [IDX_W:0]     nxt_dst;
    logic [ACC_W:0]     commit_sum;

    // Operand select for the pair currently being visited.
    always_comb begin
        mac_ci = CI_W'(src_q) * CI_W'(N_STATES) + CI_W'(dst_q);
        mac_x  = x_q[src_q];
        mac_e  = coef_q[mac_ci];
    end

    markov_flow_mac #(
        .X_W    (X_W),
        .COEF_W (COEF_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (mac_x),
        .e     (mac_e),
        .f     (mac_f)
    );

    // Flag any row whose off-diagonal outflow would exceed the whole population.
    always_comb begin
        coef_err = 1'b0;
        row_sum  = '0;
        for (int unsigned i = 0; i < N_STATES; i++) begin
            row_sum = '0;
            for (int unsigned j = 0; j < N_STATES; j++) begin
                if (i != j) begin
                    row_sum = row_sum + SUM_W'(coef_q[i*N_STATES+j]);
                end
            end
            if (row_sum > ROW_LIMIT) begin
                coef_err = 1'b1;
            end
        end
    end

    // Next-state logic: pair walk, flow accumulation, commit with saturation.
    // The MAC result lags the pair walk by one cycle, so the last pair of a
    // step is folded into the accumulators during COMMIT itself.
    always_comb begin
        state_d    = state_q;
        coef_d     = coef_q;
        x_d        = x_q;
        out_acc_d  = out_acc_q;
        in_acc_d   = in_acc_q;
        k_d        = k_q;
        step_d     = step_q;
        ovf_d      = ovf_q;
        src_d      = src_q;
        dst_d      = dst_q;
        pend_vld_d = 1'b0;
        pend_src_d = src_q;
        pend_dst_d = dst_q;
        nxt_dst    = '0;
        commit_sum = '0;

        if (pend_vld_q) begin
            out_acc_d[pend_src_q] = out_acc_q[pend_src_q] + ACC_W'(mac_f);
            in_acc_d[pend_dst_q]  = in_acc_q[pend_dst_q]  + ACC_W'(mac_f);
        end

        case (state_q)
            IDLE: begin
                if (set) begin
                    for (int unsigned k = 0; k < N_STATES*N_STATES; k++) begin
                        coef_d[k] = coef_in[k*COEF_W +: COEF_W];
                    end
                end else if (start && !coef_err) begin
                    for (int unsigned i = 0; i < N_STATES; i++) begin
                        x_d[i]       = x_in[i*X_W +: X_W];
                        out_acc_d[i] = '0;
                        in_acc_d[i]  = '0;
                    end
                    k_d    = iter_in;
                    step_d = '0;
                    ovf_d  = 1'b0;
                    src_d  = '0;
                    dst_d  = IDX_W'(1);
                    state_d = (iter_in == '0) ? DONE : FLOW;
                end
            end
            FLOW: begin
                pend_vld_d = 1'b1;
                if (src_q == IDX_W'(N_STATES-1) && dst_q == IDX_W'(N_STATES-2)) begin
                    state_d = COMMIT;
                end else begin
                    nxt_dst = {1'b0, dst_q} + 1'b1;
                    if (nxt_dst == {1'b0, src_q}) begin
                        nxt_dst = nxt_dst + 1'b1;
                    end
                    if (nxt_dst >= (IDX_W+1)'(N_STATES)) begin
                        src_d = src_q + 1'b1;
                        dst_d = '0;
                    end else begin
                        dst_d = nxt_dst[IDX_W-1:0];
                    end
                end
            end
            COMMIT: begin
                for (int unsigned i = 0; i < N_STATES; i++) begin
                    commit_sum = {{(ACC_W+1-X_W){1'b0}}, x_q[i]}
                               + {1'b0, in_acc_d[i]} - {1'b0, out_acc_d[i]};
                    if (commit_sum > X_MAX) begin
                        x_d[i] = '1;
                        ovf_d  = 1'b1;
                    end else begin
                        x_d[i] = commit_sum[X_W-1:0];
                    end
                    out_acc_d[i] = '0;
                    in_acc_d[i]  = '0;
                end
                step_d = step_q + 1'b1;
                src_d  = '0;
                dst_d  = IDX_W'(1);
                state_d = (step_d < k_q) ? FLOW : DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            step_q     <= '0;
            ovf_q      <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            pend_vld_q <= 1'b0;
            pend_src_q <= '0;
            pend_dst_q <= '0;
            for (int unsigned k = 0; k < N_STATES*N_STATES; k++) begin
                coef_q[k] <= '0;
            end
            for (int unsigned i = 0; i < N_STATES; i++) begin
                x_q[i]       <= '0;
                out_acc_q[i] <= '0;
                in_acc_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            coef_q     <= coef_d;
            x_q        <= x_d;
            out_acc_q  <= out_acc_d;
            in_acc_q   <= in_acc_d;
            k_q        <= k_d;
            step_q     <= step_d;
            ovf_q      <= ovf_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            pend_vld_q <= pend_vld_d;
            pend_src_q <= pend_src_d;
            pend_dst_q <= pend_dst_d;
        end
    end

    // Output mapping.
    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        step_cnt = step_q;
        ovf      = ovf_q;
        x_out    = '0;
        for (int unsigned i = 0; i < N_STATES; i++) begin
            x_out[i*X_W +: X_W] = x_q[i];
        end
    end

endmodule

// File: tb/tb_markov_step_engine.sv
// Self-checking bench for markov_step_engine (N=4, X_W=32, COEF_W=5, ITER_W=8).
module tb_markov_step_engine;

    localparam int N  = 4;
    localparam int XW = 32;
    localparam int CW = 5;
    localparam int IW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              set;
    logic [N*N*CW-1:0] coef_in;
    logic              start;
    logic [N*XW-1:0]   x_in;
    logic [IW-1:0]     iter_in;
    logic              busy;
    logic              done;
    logic [N*XW-1:0]   x_out;
    logic [IW-1:0]     step_cnt;
    logic              coef_err;
    logic              ovf;

    always #5 clk = ~clk;

    markov_step_engine #(
        .N_STATES (N),
        .X_W      (XW),
        .COEF_W   (CW),
        .ITER_W   (IW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .set      (set),
        .coef_in  (coef_in),
        .start    (start),
        .x_in     (x_in),
        .iter_in  (iter_in),
        .busy     (busy),
        .done     (done),
        .x_out    (x_out),
        .step_cnt (step_cnt),
        .coef_err (coef_err),
        .ovf      (ovf)
    );

    typedef int unsigned coef_arr_t [16];
    typedef logic [31:0] xv_t [4];

    typedef struct {
        string     name;
        coef_arr_t coef;
        xv_t       x;
        int        k;
        bit        use_model;
        xv_t       exp_x;
        bit        exp_ovf;
        bit        chk_sum;
        logic [63:0] exp_sum;
    } vec_t;

    typedef struct {
        string       name;
        xv_t         x;
        int          step;
        bit          ovf;
        bit          chk_sum;
        logic [63:0] sum;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Step-level reference: every flow of a step uses the pre-step vector.
    function automatic void model(input coef_arr_t c, input xv_t xi, input int k,
                                  output xv_t xo, output bit ov);
        logic [63:0] xs [4];
        logic [63:0] o  [4];
        logic [63:0] a  [4];
        logic [63:0] f, t;
        ov = 1'b0;
        for (int i = 0; i < 4; i++) xs[i] = 64'(xi[i]);
        for (int s = 0; s < k; s++) begin
            for (int i = 0; i < 4; i++) begin o[i] = 0; a[i] = 0; end
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    if (i != j) begin
                        f = (xs[i] * 64'(c[i*4+j])) >> 5;
                        o[i] = o[i] + f;
                        a[j] = a[j] + f;
                    end
            for (int i = 0; i < 4; i++) begin
                t = xs[i] + a[i] - o[i];
                if (t > 64'hFFFF_FFFF) begin
                    t  = 64'hFFFF_FFFF;
                    ov = 1'b1;
                end
                xs[i] = t;
            end
        end
        for (int i = 0; i < 4; i++) xo[i] = xs[i][31:0];
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic [63:0] s;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                e = sb.pop_front();
                s = 0;
                for (int i = 0; i < N; i++) begin
                    check($sformatf("%s_x%0d", e.name, i), 64'(x_out[i*XW +: XW]), 64'(e.x[i]));
                    s = s + 64'(x_out[i*XW +: XW]);
                end
                check({e.name, "_step_cnt"}, 64'(step_cnt), 64'(e.step));
                check({e.name, "_ovf"}, 64'(ovf), 64'(e.ovf));
                if (e.chk_sum) check({e.name, "_sum"}, s, e.sum);
            end
        end
    end

    task automatic load_coef(input coef_arr_t c);
        @(posedge clk); #1;
        set = 1'b1;
        for (int k = 0; k < 16; k++) coef_in[k*CW +: CW] = CW'(c[k]);
        @(posedge clk); #1;
        set = 1'b0;
    endtask

    task automatic drive_start(input xv_t x, input int k);
        for (int i = 0; i < N; i++) x_in[i*XW +: XW] = x[i];
        iter_in = IW'(k);
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic wait_done(input string name, input int k);
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 2000) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
        check({name, "_latency"}, 64'(n), 64'(13*k + 1));
        if (!seen) sb.delete();
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        load_coef(v.coef);
        check({v.name, "_coef_err"}, 64'(coef_err), 64'd0);
        e.name    = v.name;
        e.step    = v.k;
        e.chk_sum = v.chk_sum;
        e.sum     = v.exp_sum;
        if (v.use_model) begin
            model(v.coef, v.x, v.k, e.x, e.ovf);
        end else begin
            e.x   = v.exp_x;
            e.ovf = v.exp_ovf;
        end
        sb.push_back(e);
        drive_start(v.x, v.k);
        wait_done(v.name, v.k);
    endtask

    vec_t tbl [7];
    xv_t  x_a, x_b;
    coef_arr_t c_tmp;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int busy_seen, done_seen;
        exp_t e;

        rst_n = 1'b0; set = 1'b0; start = 1'b0;
        coef_in = '0; x_in = '0; iter_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_x_out", 64'(x_out != '0), 64'd0);
        check("rst_step_cnt", 64'(step_cnt), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_coef_err", 64'(coef_err), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        x_a = '{32'd1412442, 32'd124241, 32'd436436, 32'd63464};
        for (int t = 0; t < 7; t++) begin
            tbl[t].coef      = '{default: 0};
            tbl[t].use_model = 1'b0;
            tbl[t].exp_ovf   = 1'b0;
            tbl[t].chk_sum   = 1'b0;
            tbl[t].exp_sum   = 0;
        end
        tbl[0].name = "zero_coef";  tbl[0].x = x_a; tbl[0].k = 3; tbl[0].exp_x = x_a;
        tbl[1].name = "half_k1";    tbl[1].coef[1] = 16; tbl[1].x = '{32'd100, 32'd0, 32'd0, 32'd0};
        tbl[1].k = 1; tbl[1].exp_x = '{32'd50, 32'd50, 32'd0, 32'd0};
        tbl[2] = tbl[1]; tbl[2].name = "half_k2"; tbl[2].k = 2;
        tbl[2].exp_x = '{32'd25, 32'd75, 32'd0, 32'd0};
        tbl[3].name = "mixed_k5";   tbl[3].x = x_a; tbl[3].k = 5; tbl[3].use_model = 1'b1;
        tbl[3].coef = '{0,1,2,3, 4,0,5,6, 7,8,0,9, 0,0,0,0};
        tbl[3].chk_sum = 1'b1; tbl[3].exp_sum = 64'd2036583;
        tbl[4] = tbl[3]; tbl[4].name = "k_zero"; tbl[4].k = 0; tbl[4].use_model = 1'b0;
        tbl[4].exp_x = x_a;
        tbl[5].name = "saturate";   tbl[5].coef[4] = 31; tbl[5].k = 1;
        tbl[5].x = '{32'hFFFF_FFFF, 32'd10, 32'd0, 32'd0};
        tbl[5].exp_x = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0}; tbl[5].exp_ovf = 1'b1;
        tbl[6].name = "random_k3";  tbl[6].k = 3; tbl[6].use_model = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tbl[6].x[i] = 32'($urandom_range(0, 32'h0FFF_FFFF));
            for (int j = 0; j < 4; j++)
                if (i != j) tbl[6].coef[i*4+j] = $urandom_range(0, 10);
        end

        for (int t = 0; t < 7; t++) run_vec(tbl[t]);

        // Row sum 33 is rejected; start must be ignored.
        c_tmp = '{default: 0};
        c_tmp[1] = 16; c_tmp[2] = 16; c_tmp[3] = 1;
        load_coef(c_tmp);
        check("row33_coef_err", 64'(coef_err), 64'd1);
        drive_start(x_a, 2);
        busy_seen = 0;
        repeat (6) begin @(negedge clk); if (busy) busy_seen++; end
        check("row33_busy_cycles", 64'(busy_seen), 64'd0);
        // Row sum exactly 2^COEF_W is legal.
        c_tmp[3] = 0;
        load_coef(c_tmp);
        check("row32_coef_err", 64'(coef_err), 64'd0);

        // set together with start: only the set takes effect.
        @(posedge clk); #1;
        set = 1'b1; start = 1'b1; iter_in = 8'd2;
        coef_in = '0;
        coef_in[1*CW +: CW] = 5'd16;
        @(posedge clk); #1;
        set = 1'b0; start = 1'b0;
        busy_seen = 0;
        repeat (4) begin @(negedge clk); if (busy) busy_seen++; end
        check("set_start_busy_cycles", 64'(busy_seen), 64'd0);

        // set/start while busy are ignored: bank holds e12=16 and the run completes unchanged.
        x_b = '{32'd100, 32'd0, 32'd0, 32'd0};
        e.name = "busy_ignore"; e.step = 1; e.ovf = 1'b0; e.chk_sum = 1'b0; e.sum = 0;
        e.x = '{32'd50, 32'd50, 32'd0, 32'd0};
        sb.push_back(e);
        drive_start(x_b, 1);
        set = 1'b1; start = 1'b1;
        for (int k = 0; k < 16; k++) coef_in[k*CW +: CW] = 5'd31;
        x_in = '1; iter_in = 8'd9;
        @(posedge clk); @(posedge clk); #1;
        set = 1'b0; start = 1'b0;
        begin : busy_wait
            int n;
            n = 2;
            while (done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
            check("busy_ignore_latency", 64'(n), 64'd14);
            @(posedge clk); #1;
        end
        check("busy_ignore_bank_kept", 64'(coef_err), 64'd0);

        // Reset in the middle of a K=4 run: everything clears, no done pulse.
        load_coef(tbl[3].coef);
        drive_start(x_a, 4);
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("midrst_busy0", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_x_out", 64'(x_out != '0), 64'd0);
        check("midrst_step_cnt", 64'(step_cnt), 64'd0);
        check("midrst_ovf", 64'(ovf), 64'd0);
        check("midrst_coef_err", 64'(coef_err), 64'd0);
        #1 rst_n = 1'b1;
        done_seen = 0;
        repeat (60) begin @(negedge clk); if (done) done_seen++; end
        check("midrst_no_done", 64'(done_seen), 64'd0);
        run_vec(tbl[3]);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
